seq_div_16by8: RTL and testbench

// - Sequential restoring divider, the inverse of the 8x8 Dadda multiplier: divides a 16-bit

---
 rtl/seq_div_16by8.sv | 112 +++++++++++
 tb/tb_seq_div_16by8.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_div_16by8.sv
// Restoring 16/8 divider, one quotient bit per clock; start/done handshake, start ignored unless idle.
// Latency 16 cycles from accepted start to done (1 cycle for b==0 or a<b when DIV_FAST_EXIT_EN is defined).
// No queuing: start while busy or in done is dropped; quo/rem/dz hold until the next done.
module seq_div_16by8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] quo,
  output logic [7:0]  rem,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] dvd;
  logic [7:0]  dvs;
  logic [7:0]  pr;
  logic [3:0]  cnt;
  logic [15:0] q;

  logic [8:0]  shifted;
  logic        fit;
  logic [7:0]  pr_nxt;
  logic [15:0] q_nxt;
  logic        fast_exit;

  // Partial remainder stays below the divisor, so an 8-bit difference is exact whenever it fits.
  always_comb begin
    shifted    = {pr, dvd[cnt]};
    fit        = (shifted >= {1'b0, dvs});
    pr_nxt     = fit ? (shifted[7:0] - dvs) : shifted[7:0];
    q_nxt      = q;
    q_nxt[cnt] = fit;
  end

`ifdef DIV_FAST_EXIT_EN
  assign fast_exit = (b == 8'h00) || (a < {8'h00, b});
`else
  assign fast_exit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = fast_exit ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd <= '0;
      dvs <= '0;
      pr  <= '0;
      cnt <= '0;
      q   <= '0;
      quo <= '0;
      rem <= '0;
      dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd <= a;
            dvs <= b;
            pr  <= '0;
            cnt <= 4'd15;
            q   <= '0;
            if (fast_exit) begin
              quo <= (b == 8'h00) ? 16'hFFFF : 16'h0000;
              rem <= a[7:0];
              dz  <= (b == 8'h00);
            end
          end
        end
        CALC: begin
          pr  <= pr_nxt;
          q   <= q_nxt;
          cnt <= cnt - 4'd1;
          // Divide-by-zero still runs the full sequence; results are overridden at the end.
          if (cnt == 4'd0) begin
            quo <= (dvs == 8'h00) ? 16'hFFFF : q_nxt;
            rem <= (dvs == 8'h00) ? dvd[7:0] : pr_nxt;
            dz  <= (dvs == 8'h00);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_16by8.sv
// Bench for seq_div_16by8: directed vector table, corner sequences, and random operands vs arithmetic model.
module tb_seq_div_16by8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [7:0]  b;
  logic        busy, done, dz;
  logic [15:0] quo;
  logic [7:0]  rem;

  int n_checks = 0;
  int n_pass   = 0;

  seq_div_16by8 dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] quo;
    logic [7:0]  rem;
    logic        dz;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int exp_latency(input logic [15:0] ta, input logic [7:0] tb_);
`ifdef DIV_FAST_EXIT_EN
    if (tb_ == 8'h00 || ta < {8'h00, tb_}) return 0;
`endif
    return 16;
  endfunction

  // Launches one division and checks latency, busy, result and the one-cycle done pulse.
  // n counts rising edges after the accepting edge at which done is first seen.
  task automatic run_div(input logic [15:0] ta, input logic [7:0] tb_,
                         input logic [15:0] eq, input logic [7:0] er, input logic ed,
                         input bit glitch);
    int  n;
    int  elat;
    bit  seen;
    elat = exp_latency(ta, tb_);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 8'($urandom);
    chk("busy_after_accept", 32'(busy), 32'(elat != 0));
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      if (done) seen = 1;
      else begin
        start = (glitch && n == 4);
        @(negedge clk);
        start = 1'b0;
        n++;
      end
    end
    if (!seen) begin
      chk("done_timeout", 32'(n), 32'(elat));
    end else begin
      chk("latency", 32'(n), 32'(elat));
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("quo", 32'(quo), 32'(eq));
      chk("rem", 32'(rem), 32'(er));
      chk("dz", 32'(dz), 32'(ed));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("quo_hold", 32'(quo), 32'(eq));
    end
  endtask

  task automatic run_model(input logic [15:0] ta, input logic [7:0] tb_);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ed;
    if (tb_ == 8'h00) begin
      eq = 16'hFFFF; er = ta[7:0]; ed = 1'b1;
    end else begin
      eq = ta / {8'h00, tb_};
      er = 8'(ta % {8'h00, tb_});
      ed = 1'b0;
    end
    run_div(ta, tb_, eq, er, ed, 1'b0);
  endtask

  initial begin
    bit saw_done;
    logic [15:0] ra;
    logic [7:0]  rb;

    vecs[0]  = '{16'd387,   8'd9,   16'd43,    8'd0,   1'b0};
    vecs[1]  = '{16'd3139,  8'd73,  16'd43,    8'd0,   1'b0};
    vecs[2]  = '{16'd3139,  8'd43,  16'd73,    8'd0,   1'b0};
    vecs[3]  = '{16'd2116,  8'd9,   16'd235,   8'd1,   1'b0};
    vecs[4]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
    vecs[5]  = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0};
    vecs[6]  = '{16'd1000,  8'd0,   16'hFFFF,  8'hE8, 1'b1};
    vecs[7]  = '{16'd1000,  8'd5,   16'd200,   8'd0,   1'b0};
    vecs[8]  = '{16'd5,     8'd7,   16'd0,     8'd5,   1'b0};
    vecs[9]  = '{16'd0,     8'd17,  16'd0,     8'd0,   1'b0};
    vecs[10] = '{16'd200,   8'd201, 16'd0,     8'd200, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quo", 32'(quo), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_div(vecs[i].a, vecs[i].b, vecs[i].quo, vecs[i].rem, vecs[i].dz, 1'b0);

    // Stray start mid-operation must not disturb the running division.
    run_div(16'd3139, 8'd73, 16'd43, 8'd0, 1'b0, 1'b1);

    // Reset sampled at the eighth iteration edge aborts without a done.
    @(negedge clk);
    a = 16'd3139; b = 8'd43; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy_mid_op", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quo", 32'(quo), 32'd0);
    chk("abort_rem", 32'(rem), 32'd0);
    chk("abort_dz", 32'(dz), 32'd0);
    saw_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    run_div(16'd2116, 8'd9, 16'd235, 8'd1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case (i % 4)
        0: rb = 8'($urandom_range(1, 255));
        1: rb = 8'($urandom_range(0, 3));
        2: begin rb = 8'($urandom_range(1, 255)); ra = 16'($urandom_range(0, 300)); end
        default: rb = 8'($urandom);
      endcase
      run_model(ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
